// File: rtl/ui_in_debouncer.sv
// ui_in_debouncer: 2-flop sync, per-bit debounce and registered rise/fall pulses for ui_in.
// Optional latched edge flags enabled by defining DBNC_STICKY_EN.
module ui_in_debouncer #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 1000,
    parameter int               CNT_W           = 16,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] sticky,
    input  logic [WIDTH-1:0] sticky_clr
);
    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_cfg
        $error("ui_in_debouncer: DEBOUNCE_CYCLES must be >= 1 and < 2**CNT_W");
    end
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0] sync1_q, sync2_q, dout_q, dout_d, rise_q, fall_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        logic differ, settle;
        assign differ    = sync2_q[i] != dout_q[i];
        assign settle    = differ && ena && cnt_q[i] == LAST;
        assign cnt_d[i]  = (!differ || settle) ? '0 : ena ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
        assign dout_d[i] = settle ? sync2_q[i] : dout_q[i];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            dout_q  <= RESET_VAL;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int k = 0; k < WIDTH; k++) cnt_q[k] <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            dout_q  <= dout_d;
            rise_q  <= dout_d & ~dout_q;
            fall_q  <= ~dout_d & dout_q;
            cnt_q   <= cnt_d;
        end
    end
    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
`ifdef DBNC_STICKY_EN
    // A fresh edge overrides a clear arriving on the same cycle.
    logic [WIDTH-1:0] sticky_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= '0;
        else sticky_q <= (sticky_q & ~sticky_clr) | (dout_d ^ dout_q);
    end
    assign sticky = sticky_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = ^sticky_clr;
    assign sticky = '0;
`endif
endmodule

// File: tb/tb_ui_in_debouncer.sv
// tb_ui_in_debouncer: vector table, corner sequences and random run against a reference model.
module tb_ui_in_debouncer;
    localparam int DC = 4;
`ifdef DBNC_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
    logic [7:0] din = 8'h00, sticky_clr = 8'h00;
    logic [7:0] dout, rise, fall, sticky;
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    ui_in_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(DC), .CNT_W(16), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .dout(dout),
        .rise(rise), .fall(fall), .sticky(sticky), .sticky_clr(sticky_clr)
    );

    logic [7:0] m_s1, m_s2, m_dout, m_rise, m_fall, m_st;
    int run [8];

    task automatic mreset();
        m_s1 = 0; m_s2 = 0; m_dout = 0; m_rise = 0; m_fall = 0; m_st = 0;
        foreach (run[b]) run[b] = 0;
    endtask

    // Each bit needs DC enabled mismatching cycles in a row before its level follows.
    task automatic mstep();
        logic [7:0] prev;
        if (!rst_n) begin
            mreset();
            return;
        end
        prev = m_dout;
        for (int b = 0; b < 8; b++) begin
            if (m_s2[b] == m_dout[b]) run[b] = 0;
            else if (ena) begin
                run[b]++;
                if (run[b] == DC) begin
                    m_dout[b] = m_s2[b];
                    run[b] = 0;
                end
            end
        end
        m_rise = m_dout & ~prev;
        m_fall = prev & ~m_dout;
        if (STK) m_st = (m_st & ~sticky_clr) | m_rise | m_fall;
        m_s2 = m_s1;
        m_s1 = din;
    endtask

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        mstep();
        #1;
    endtask

    task automatic set_rst(logic v);
        rst_n = v;
        if (!v) mreset();
    endtask

    typedef struct {
        logic [7:0] din;
        logic       rst;
        logic [7:0] dout, rise, fall;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(int n, logic [7:0] d, logic r, logic [7:0] o, logic [7:0] ri, logic [7:0] fa);
        vec_t v;
        v.din = d; v.rst = r; v.dout = o; v.rise = ri; v.fall = fa;
        repeat (n) tbl.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        mreset();
        add(3, 8'hFF, 0, 8'h00, 8'h00, 8'h00);
        add(4, 8'h00, 1, 8'h00, 8'h00, 8'h00);
        add(5, 8'h01, 1, 8'h00, 8'h00, 8'h00);
        add(1, 8'h01, 1, 8'h01, 8'h01, 8'h00);
        add(2, 8'h01, 1, 8'h01, 8'h00, 8'h00);
        add(3, 8'h09, 1, 8'h01, 8'h00, 8'h00);
        add(6, 8'h01, 1, 8'h01, 8'h00, 8'h00);
        add(4, 8'h09, 1, 8'h01, 8'h00, 8'h00);
        add(1, 8'h01, 1, 8'h01, 8'h00, 8'h00);
        add(1, 8'h01, 1, 8'h09, 8'h08, 8'h00);
        add(3, 8'h01, 1, 8'h09, 8'h00, 8'h00);
        add(1, 8'h01, 1, 8'h01, 8'h00, 8'h08);
        add(1, 8'h01, 1, 8'h01, 8'h00, 8'h00);
        din = 8'hFF;
        set_rst(0);
        #1;
        check("reset_async dout", dout, 8'h00);
        foreach (tbl[i]) begin
            din = tbl[i].din;
            set_rst(tbl[i].rst);
            tick();
            check($sformatf("vec%0d dout", i), dout, tbl[i].dout);
            check($sformatf("vec%0d rise", i), rise, tbl[i].rise);
            check($sformatf("vec%0d fall", i), fall, tbl[i].fall);
            if (!tbl[i].rst) check($sformatf("vec%0d sticky", i), sticky, 8'h00);
        end

        din = 8'h03;
        n = 0;
        while (!dout[1] && n < 40) begin
            ena = !(n >= 4 && n < 14);
            tick();
            n++;
        end
        ena = 1'b1;
        check("ena_gate latency", 8'(n), 8'd16);
        check("ena_gate rise", rise, 8'h02);

        din = 8'h82;
        repeat (5) tick();
        check("multi pre dout", dout, 8'h03);
        check("multi pre pulses", rise | fall, 8'h00);
        tick();
        check("multi dout", dout, 8'h82);
        check("multi rise", rise, 8'h80);
        check("multi fall", fall, 8'h01);

        din = 8'h83;
        repeat (3) tick();
        set_rst(0);
        #1;
        check("midrst dout", dout, 8'h00);
        check("midrst pulses", rise | fall, 8'h00);
        repeat (2) begin
            tick();
            check("inrst dout", dout, 8'h00);
            check("inrst pulses", rise | fall | sticky, 8'h00);
        end
        set_rst(1);
        repeat (5) tick();
        check("restart early dout", dout, 8'h00);
        tick();
        check("restart dout", dout, 8'h83);
        check("restart rise", rise, 8'h83);

        sticky_clr = 8'hFF;
        tick();
        sticky_clr = 8'h00;
        check("sticky clr_all", sticky, 8'h00);
        din = 8'h87;
        repeat (6) tick();
        check("sticky rise2", rise, 8'h04);
        check("sticky set", sticky, STK ? 8'h04 : 8'h00);
        repeat (3) tick();
        check("sticky held", sticky, STK ? 8'h04 : 8'h00);
        din = 8'h83;
        repeat (5) tick();
        sticky_clr = 8'h04;
        tick();
        check("sticky fall2", fall, 8'h04);
        check("sticky set_wins", sticky, STK ? 8'h04 : 8'h00);
        tick();
        sticky_clr = 8'h00;
        check("sticky cleared", sticky, 8'h00);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) din = din ^ 8'($urandom);
            ena = $urandom_range(0, 9) != 0;
            sticky_clr = 8'($urandom & $urandom & $urandom);
            if (!rst_n) set_rst(1);
            else if ($urandom_range(0, 599) == 0) set_rst(0);
            tick();
            check("rand dout", dout, m_dout);
            check("rand rise", rise, m_rise);
            check("rand fall", fall, m_fall);
            check("rand sticky", sticky, m_st);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
